// File: rtl/async_fifo_wr_ctrl.sv
// rtl/async_fifo_wr_ctrl.sv - write-domain pointer, flag, level and overflow controller for the async FIFO
module async_fifo_wr_ctrl #(
    parameter int FIFO_DEPTH   = 8,
    parameter int SIZE         = $clog2(FIFO_DEPTH),
    parameter int AFULL_THRESH = FIFO_DEPTH - 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            wr_en_i,
    input  logic            clr_ovf_i,
    input  logic [SIZE:0]   rd_addr_gray_synced_i,
    output logic            wr_ram_en_o,
    output logic [SIZE-1:0] wr_addr_o,
    output logic [SIZE:0]   wr_addr_gray_o,
    output logic            full_o,
    output logic            almost_full_o,
    output logic [SIZE:0]   level_o,
    output logic            overflow_o
);

    localparam logic [SIZE:0] LP_THRESH = (SIZE+1)'(AFULL_THRESH);

    logic [SIZE:0] r_wr_bin;
    logic [SIZE:0] r_wr_gray;
    logic [SIZE:0] r_level;
    logic          r_full;
    logic          r_afull;
    logic          r_ovf;

    logic          w_push;
    logic [SIZE:0] w_wr_bin_next;
    logic [SIZE:0] w_wr_gray_next;
    logic [SIZE:0] w_rd_bin;
    logic [SIZE:0] w_level_next;
    logic [SIZE:0] w_full_gray;

    // Each binary bit is the XOR of all Gray bits at and above it.
    always_comb begin
        w_rd_bin = '0;
        for (int i = 0; i <= SIZE; i++) begin
            w_rd_bin[i] = ^(rd_addr_gray_synced_i >> i);
        end
    end

    // Full when the write pointer is exactly one lap ahead of the read pointer.
    assign w_full_gray    = {~rd_addr_gray_synced_i[SIZE:SIZE-1], rd_addr_gray_synced_i[SIZE-2:0]};
    assign w_push         = wr_en_i & ~r_full;
    assign w_wr_bin_next  = r_wr_bin + {{SIZE{1'b0}}, w_push};
    assign w_wr_gray_next = w_wr_bin_next ^ (w_wr_bin_next >> 1);
    assign w_level_next   = w_wr_bin_next - w_rd_bin;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_bin  <= '0;
            r_wr_gray <= '0;
            r_level   <= '0;
            r_full    <= 1'b0;
            r_afull   <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_wr_bin  <= w_wr_bin_next;
            r_wr_gray <= w_wr_gray_next;
            r_level   <= w_level_next;
            r_full    <= (w_wr_gray_next == w_full_gray);
            r_afull   <= (w_level_next >= LP_THRESH);
            if (wr_en_i && r_full) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf_i) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign wr_ram_en_o    = w_push;
    assign wr_addr_o      = r_wr_bin[SIZE-1:0];
    assign wr_addr_gray_o = r_wr_gray;
    assign full_o         = r_full;
    assign almost_full_o  = r_afull;
    assign level_o        = r_level;
    assign overflow_o     = r_ovf;

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// tb/tb_async_fifo_wr_ctrl.sv - scoreboard bench for async_fifo_wr_ctrl against a count-based model
module tb_async_fifo_wr_ctrl;

    localparam int DEPTH = 8;
    localparam int SIZE  = 3;
    localparam int TH    = DEPTH - 2;
    localparam int PMOD  = 2 * DEPTH;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            wr_en = 1'b0;
    logic            clr_ovf = 1'b0;
    logic [SIZE:0]   rd_gray = '0;
    logic            wr_ram_en;
    logic [SIZE-1:0] wr_addr;
    logic [SIZE:0]   wr_gray;
    logic            full;
    logic            afull;
    logic [SIZE:0]   level;
    logic            ovf;

    async_fifo_wr_ctrl #(
        .FIFO_DEPTH  (DEPTH),
        .AFULL_THRESH(TH)
    ) dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .wr_en_i              (wr_en),
        .clr_ovf_i            (clr_ovf),
        .rd_addr_gray_synced_i(rd_gray),
        .wr_ram_en_o          (wr_ram_en),
        .wr_addr_o            (wr_addr),
        .wr_addr_gray_o       (wr_gray),
        .full_o               (full),
        .almost_full_o        (afull),
        .level_o              (level),
        .overflow_o           (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int en;
        int addr;
        int gray;
        int full;
        int afull;
        int level;
        int ovf;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    // Model: total writes accepted and total reads seen, as plain counters.
    int   m_wtot, m_rcnt, m_level, m_ovf;
    bit   m_full, m_afull;

    function automatic int gray_of(input int b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_wtot = 0; m_rcnt = 0; m_level = 0; m_ovf = 0; m_full = 0; m_afull = 0;
    endtask

    task automatic step(input bit wr, input bit clr, input int rcnt_new);
        exp_t e;
        int   lvl;
        bit   push;
        @(posedge clk);
        #1;
        wr_en   = wr;
        clr_ovf = clr;
        rd_gray = (SIZE+1)'(gray_of(rcnt_new % PMOD));
        push    = wr && !m_full;
        e.en    = int'(push);
        e.addr  = m_wtot % DEPTH;
        e.gray  = gray_of(m_wtot % PMOD);
        e.full  = int'(m_full);
        e.afull = int'(m_afull);
        e.level = m_level;
        e.ovf   = m_ovf;
        q.push_back(e);
        if (wr && m_full) m_ovf = 1;
        else if (clr)     m_ovf = 0;
        m_wtot  = m_wtot + int'(push);
        m_rcnt  = rcnt_new;
        lvl     = m_wtot - m_rcnt;
        m_level = lvl;
        m_full  = (lvl == DEPTH);
        m_afull = (lvl >= TH);
    endtask

    always @(negedge clk) begin
        if (mon_en && q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("wr_ram_en", int'(wr_ram_en), e.en);
            chk("wr_addr", int'(wr_addr), e.addr);
            chk("wr_addr_gray", int'(wr_gray), e.gray);
            chk("full", int'(full), e.full);
            chk("almost_full", int'(afull), e.afull);
            chk("level", int'(level), e.level);
            chk("overflow", int'(ovf), e.ovf);
        end
    end

    task automatic async_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_wr_gray", int'(wr_gray), 0);
        chk("rst_full", int'(full), 0);
        chk("rst_afull", int'(afull), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_overflow", int'(ovf), 0);
        mon_en  = 1'b0;
        q.delete();
        wr_en   = 1'b0;
        clr_ovf = 1'b0;
        rd_gray = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        // Idle after reset.
        repeat (3) step(0, 0, 0);

        // Eight writes fill the FIFO, then blocked writes and overflow handling.
        repeat (8) step(1, 0, 0);
        repeat (3) step(1, 0, 0);
        step(0, 1, 0);
        step(0, 0, 0);
        step(1, 1, 0);
        step(0, 0, 0);
        step(0, 1, 0);
        step(0, 0, 0);

        // Read pointer jumps to 3: level 5, then one write to 6.
        step(0, 0, 3);
        step(1, 0, 3);
        step(0, 0, 3);

        // Randomised interleaving with wrap-around; reads never pass accepted writes.
        for (int i = 0; i < 300; i++) begin
            bit wr, clr;
            int rc;
            wr  = ($urandom_range(0, 99) < 60);
            clr = ($urandom_range(0, 99) < 10);
            rc  = m_rcnt;
            if (m_wtot > m_rcnt && $urandom_range(0, 99) < 50) rc = m_rcnt + 1;
            step(wr, clr, rc);
        end
        step(0, 0, m_rcnt);

        // Mid-fill asynchronous reset at level 5, then first write.
        async_reset();
        repeat (5) step(1, 0, 0);
        step(0, 0, 0);
        async_reset();
        step(1, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
